axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
AXI4-Lite master bridge that sits directly upstream of the team's 4-register AXI4-Lite slave. It converts a simple valid/ready command stream (read or write, address, data, strobe) into single AXI4-Lite transactions and returns one response per command on a valid/ready response stream. At most one transaction is outstanding; there are no BRESP/RRESP channels, matching the slave's port set.

Parameters:
ADDR_WIDTH, 4, AXI address width; forwarded unchanged to AWADDR/ARADDR.
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with AXIM_TIMEOUT_EN.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESETn  in  1  reset; synchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_WIDTH  byte address.
cmd_wdata  in  DATA_WIDTH  write data.
cmd_wstrb  in  DATA_WIDTH/8  byte strobes.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_is_write  out  1  response belongs to a write.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
rsp_err  out  1  timeout flag; constant 0 without AXIM_TIMEOUT_EN.
AWADDR/AWVALID out, AWREADY in: write address channel.
WDATA/WSTRB/WVALID out, WREADY in: write data channel.
BVALID in, BREADY out: write response channel.
ARADDR/ARVALID out, ARREADY in: read address channel.
RDATA in, RVALID in, RREADY out: read data channel.

Behaviour:
- Reset (ARESETn low at a rising edge): state=IDLE. cmd_ready=0, rsp_valid=0, rsp_is_write=0, rsp_rdata=0, rsp_err=0. AWVALID=WVALID=BREADY=ARVALID=RREADY=0. AWADDR=WDATA=WSTRB=ARADDR=0. Watchdog=0.
- Reset mid-transaction aborts the transaction immediately. Any in-flight command or response is discarded.
- All outputs are registered.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_* and deassert cmd_ready.
  - Write: next cycle AWVALID=WVALID=1, AWADDR/WDATA/WSTRB = latched values; go to WR_REQ.
  - Read: next cycle ARVALID=1, ARADDR = latched address; go to RD_REQ.
- WR_REQ:
  - AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY. The two handshakes complete independently, in either order or together.
  - Payloads stay stable while their VALID is high.
  - When both handshakes are done, set BREADY=1 and go to WR_RESP.
- WR_RESP: on BVALID&&BREADY, set BREADY=0, rsp_is_write=1, rsp_rdata=0, rsp_valid=1; go to RSP.
- RD_REQ: ARVALID held until ARVALID&&ARREADY; then ARVALID=0, RREADY=1; go to RD_DATA.
- RD_DATA: on RVALID&&RREADY, capture RDATA into rsp_rdata, set RREADY=0, rsp_is_write=0, rsp_valid=1; go to RSP.
- RSP: rsp_* held stable until rsp_valid&&rsp_ready; then rsp_valid=0; go to IDLE. cmd_ready rises the following cycle.
- cmd_ready is 0 in every state except IDLE. No command overlaps a pending response.
- The address is passed through unaligned. The slave decodes bits [3:2]; this block never masks the address.
- Minimum command-to-response latency with an always-ready slave: write ≤4 cycles, read ≤4 cycles.

Optional Feature:
Macro: AXIM_TIMEOUT_EN.
- Enabled: a watchdog counter clears on every state entry and increments each cycle in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
- On reaching TIMEOUT_CYCLES: drop all AXI VALID/READY outputs, set rsp_err=1, rsp_rdata=0, rsp_is_write=latched cmd_write, rsp_valid=1; go to RSP.
- This is a deliberate protocol abort for fault containment.
- Disabled: no counter logic; rsp_err is tied 0; the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds the state enum axim_state_t, a default TIMEOUT_CYCLES constant, and a command struct axim_cmd_t {write, addr, wdata, wstrb}.
- One natural sub-module: axim_watchdog (counter, clear/enable inputs, expire output), instantiated only under AXIM_TIMEOUT_EN.

Test Plan:
- Write then read back: write addr 0x4, data 0xDEADBEEF, wstrb 0xF to the slave, then read addr 0x4 → write response rsp_is_write=1, rsp_err=0; read response rsp_rdata=0xDEADBEEF.
- Partial strobe: write 0x0=0x11223344 (wstrb 0xF), then write 0x0=0xAABBCCDD (wstrb 0x5), then read 0x0 → rsp_rdata=0x11BB33DD.
- Response backpressure: hold rsp_ready=0 for 10 cycles after a read → rsp_valid and rsp_rdata stay stable, cmd_ready=0 throughout, one response delivered on release.
- Stub slave delays AWREADY 3 cycles after WREADY → WVALID drops first, AWVALID is held until its handshake, BREADY rises only after both handshakes complete.
- Reset mid-operation: assert ARESETn=0 while in WR_RESP → next cycle all outputs are at their reset values; a subsequent read succeeds.
- With AXIM_TIMEOUT_EN, a stub slave never asserts RVALID → response arrives TIMEOUT_CYCLES=16 cycles into RD_DATA with rsp_err=1, rsp_rdata=0, RREADY=0.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared state encoding, command record and watchdog default for axi_lite_cmd_master.
package axi_lite_pkg;
    localparam int AXIM_ADDR_W          = 4;
    localparam int AXIM_DATA_W          = 32;
    localparam int AXIM_TIMEOUT_DEFAULT = 16;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} axim_state_t;
    typedef struct packed {
        logic                     write;
        logic [AXIM_ADDR_W-1:0]   addr;
        logic [AXIM_DATA_W-1:0]   wdata;
        logic [AXIM_DATA_W/8-1:0] wstrb;
    } axim_cmd_t;
endpackage

// File: rtl/axim_watchdog.sv
// axim_watchdog: counts enabled cycles since the last clear and flags expiry on the LIMIT-th cycle.
module axim_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic ACLK,
    input  logic ARESETn,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge ACLK) cnt_q <= !ARESETn ? '0 : cnt_d;
    assign expire = en && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: valid/ready command stream to single AXI4-Lite transactions, one response each.
// Define AXIM_TIMEOUT_EN to add a watchdog that aborts a stalled transaction with rsp_err.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = AXIM_TIMEOUT_DEFAULT
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_is_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic                    RVALID,
    output logic                    RREADY
);
    axim_state_t             state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_is_write_q, rsp_is_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                    arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    wr_q, wr_d;
    logic                    timeout;
`ifdef AXIM_TIMEOUT_EN
    axim_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .clr     (state_d != state_q),
        .en      (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}),
        .expire  (timeout)
    );
`else
    logic unused_timeout;
    assign timeout        = 1'b0;
    assign unused_timeout = wr_q ^ (TIMEOUT_CYCLES != 0);
`endif
    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = 1'b0;
        rsp_valid_d    = rsp_valid_q;
        rsp_is_write_d = rsp_is_write_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        awvalid_d      = awvalid_q;
        wvalid_d       = wvalid_q;
        bready_d       = bready_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        awaddr_d       = awaddr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        araddr_d       = araddr_q;
        wr_d           = wr_q;
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    wr_d        = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // address and data handshakes retire independently
                awvalid_d = awvalid_q && !AWREADY;
                wvalid_d  = wvalid_q && !WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID && bready_q) begin
                    bready_d       = 1'b0;
                    rsp_is_write_d = 1'b1;
                    rsp_rdata_d    = '0;
                    rsp_err_d      = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = RSP;
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID && rready_q) begin
                    rready_d       = 1'b0;
                    rsp_is_write_d = 1'b0;
                    rsp_rdata_d    = RDATA;
                    rsp_err_d      = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = RSP;
                end
            end
            RSP: begin
                if (rsp_ready && rsp_valid_q) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            awvalid_d      = 1'b0;
            wvalid_d       = 1'b0;
            bready_d       = 1'b0;
            arvalid_d      = 1'b0;
            rready_d       = 1'b0;
            rsp_err_d      = 1'b1;
            rsp_rdata_d    = '0;
            rsp_is_write_d = wr_q;
            rsp_valid_d    = 1'b1;
            state_d        = RSP;
        end
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            bready_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            awaddr_q       <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            araddr_q       <= '0;
            wr_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_write_q <= rsp_is_write_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            awvalid_q      <= awvalid_d;
            wvalid_q       <= wvalid_d;
            bready_q       <= bready_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            awaddr_q       <= awaddr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            araddr_q       <= araddr_d;
            wr_q           <= wr_d;
        end
    end
    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_is_write = rsp_is_write_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign AWADDR       = awaddr_q;
    assign AWVALID      = awvalid_q;
    assign WDATA        = wdata_q;
    assign WSTRB        = wstrb_q;
    assign WVALID       = wvalid_q;
    assign BREADY       = bready_q;
    assign ARADDR       = araddr_q;
    assign ARVALID      = arvalid_q;
    assign RREADY       = rready_q;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: stub 4-register slave with tunable delays, register-array reference model,
// directed table, multi-cycle corner sequences and randomized traffic.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;
    import axi_lite_pkg::*;

    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr, cmd_wstrb;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_is_write, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  AWADDR, ARADDR, WSTRB;
    logic [31:0] WDATA, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;

    int errors = 0;
    int checks = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit r_never = 0;
    logic [31:0] smem  [4];
    logic [31:0] model [4];
    logic [3:0]  last_awa, last_ara;

    typedef struct {
        axim_cmd_t   cmd;
        logic [31:0] exp_rdata;
    } vec_t;

    axi_lite_cmd_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Stub slave: acts on the falling edge, so handshakes seen here complete at the next rising edge.
    initial begin : slave
        bit aw_h = 0, w_h = 0, b_h = 0, ar_h = 0, r_h = 0, rst_h = 1;
        bit got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
        int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
        logic [3:0]  awa_s, ara_s, ws_s, awa, ws;
        logic [31:0] wd_s, wd;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; RDATA = 0;
        forever begin
            @(negedge ACLK);
            if (rst_h) begin
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
                for (int i = 0; i < 4; i++) smem[i] = 0;
            end else begin
                if (aw_h) begin got_aw = 1; awa = awa_s; last_awa = awa_s; end
                if (w_h) begin got_w = 1; wd = wd_s; ws = ws_s; end
                if (b_h) b_pend = 0;
                if (ar_h) begin r_pend = 1; r_c = 0; RDATA = smem[ara_s[3:2]]; last_ara = ara_s; end
                if (r_h) r_pend = 0;
                if (got_aw && got_w) begin
                    for (int i = 0; i < 4; i++)
                        if (ws[i]) smem[awa[3:2]][8*i +: 8] = wd[8*i +: 8];
                    got_aw = 0; got_w = 0; b_pend = 1; b_c = 0;
                end
            end
            aw_c = AWVALID ? aw_c + 1 : 0;  AWREADY = AWVALID && aw_c > aw_dly;
            w_c  = WVALID  ? w_c + 1  : 0;  WREADY  = WVALID && w_c > w_dly;
            ar_c = ARVALID ? ar_c + 1 : 0;  ARREADY = ARVALID && ar_c > ar_dly;
            b_c  = b_pend  ? b_c + 1  : 0;  BVALID  = b_pend && b_c > b_dly;
            r_c  = r_pend  ? r_c + 1  : 0;  RVALID  = r_pend && !r_never && r_c > r_dly;
            rst_h = !ARESETn;
            aw_h = AWVALID && AWREADY; awa_s = AWADDR;
            w_h  = WVALID && WREADY;   wd_s = WDATA; ws_s = WSTRB;
            b_h  = BVALID && BREADY;
            ar_h = ARVALID && ARREADY; ara_s = ARADDR;
            r_h  = RVALID && RREADY;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    function automatic vec_t mk(input bit w, input logic [3:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.cmd.write = w; v.cmd.addr = a; v.cmd.wdata = d; v.cmd.wstrb = s; v.exp_rdata = e;
        return v;
    endfunction

    task automatic rst_chk(input string tag);
        chk({tag, "_ctrl"}, {cmd_ready, rsp_valid, rsp_is_write, rsp_err,
                             AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
        chk({tag, "_data"}, {rsp_rdata, WDATA}, 0);
        chk({tag, "_addr"}, {AWADDR, WSTRB, ARADDR}, 0);
    endtask

    task automatic send_cmd(input axim_cmd_t c);
        int n = 0;
        cmd_valid = 1; cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
        while (!cmd_ready && n < 40) begin tick(); n++; end
        chk("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 0;
    endtask

    task automatic get_rsp(input int hold, output bit iw, output logic [31:0] rd, output bit er,
                           output int lat, output bit stable, output logic [4:0] ax);
        logic [31:0] r0;
        lat = 0; stable = 1;
        while (!rsp_valid && lat < 100) begin tick(); lat++; end
        chk("rsp_arrive", rsp_valid, 1);
        ax = {AWVALID, WVALID, BREADY, ARVALID, RREADY};
        r0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!rsp_valid || rsp_rdata !== r0 || cmd_ready) stable = 0;
        end
        iw = rsp_is_write; rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("rsp_consumed", rsp_valid, 0);
    endtask

    task automatic run_check(input string tag, input axim_cmd_t c, input logic [31:0] exp,
                             input int hold, output int lat, output bit stable);
        bit iw, er;
        logic [31:0] rd;
        logic [4:0] ax;
        send_cmd(c);
        get_rsp(hold, iw, rd, er, lat, stable, ax);
        chk({tag, "_is_write"}, iw, c.write);
        chk({tag, "_rdata"}, rd, exp);
        chk({tag, "_err"}, er, 0);
        chk({tag, "_axi_idle"}, ax, 0);
        chk({tag, "_addr_pass"}, c.write ? last_awa : last_ara, c.addr);
        if (c.write) model[c.addr[3:2]] = merge(model[c.addr[3:2]], c.wdata, c.wstrb);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        vec_t tbl [8];
        int lat, w_drop, aw_drop, b_rise, n;
        bit stable, early, addr_moved;
        axim_cmd_t c;
        tbl[0] = mk(1, 4'h4, 32'hDEADBEEF, 4'hF, 32'h0);
        tbl[1] = mk(0, 4'h4, 32'h0,        4'h0, 32'hDEADBEEF);
        tbl[2] = mk(1, 4'h0, 32'h11223344, 4'hF, 32'h0);
        tbl[3] = mk(1, 4'h0, 32'hAABBCCDD, 4'h5, 32'h0);
        tbl[4] = mk(0, 4'h0, 32'h0,        4'h0, 32'h11BB33DD);
        tbl[5] = mk(0, 4'h7, 32'h0,        4'h0, 32'hDEADBEEF);
        tbl[6] = mk(1, 4'hE, 32'h000000FF, 4'h1, 32'h0);
        tbl[7] = mk(0, 4'hC, 32'h0,        4'h0, 32'h000000FF);
        ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        tick(); tick();
        rst_chk("reset");
        ARESETn = 1;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);

        foreach (tbl[i]) begin
            run_check($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].exp_rdata, 0, lat, stable);
            chk($sformatf("tbl%0d_latency_le4", i), lat <= 4, 1);
        end

        // Response backpressure: ten cycles of rsp_ready=0 on a read.
        c = mk(0, 4'h4, 0, 0, 0).cmd;
        run_check("bp", c, 32'hDEADBEEF, 10, lat, stable);
        chk("bp_stable", stable, 1);

        // AWREADY three cycles behind WREADY.
        aw_dly = 3;
        c = mk(1, 4'h8, 32'h55AA55AA, 4'hF, 0).cmd;
        send_cmd(c);
        w_drop = -1; aw_drop = -1; b_rise = -1; early = 0; addr_moved = 0;
        for (int k = 1; k <= 20 && b_rise < 0; k++) begin
            tick();
            if (!WVALID && w_drop < 0) w_drop = k;
            if (!AWVALID && aw_drop < 0) aw_drop = k;
            if (BREADY && b_rise < 0) b_rise = k;
            if (AWVALID && AWADDR !== 4'h8) addr_moved = 1;
            if (BREADY && (AWVALID || WVALID)) early = 1;
        end
        chk("awdly_wvalid_drop", w_drop, 1);
        chk("awdly_awvalid_drop", aw_drop, 4);
        chk("awdly_bready_rise", b_rise, 4);
        chk("awdly_bready_early", early, 0);
        chk("awdly_awaddr_stable", addr_moved, 0);
        begin
            bit iw, er; logic [31:0] rd; logic [4:0] ax;
            get_rsp(0, iw, rd, er, lat, stable, ax);
            chk("awdly_is_write", iw, 1);
            chk("awdly_err", er, 0);
        end
        model[2] = merge(model[2], 32'h55AA55AA, 4'hF);
        aw_dly = 0;
        c = mk(0, 4'h8, 0, 0, 0).cmd;
        run_check("awdly_rb", c, model[2], 0, lat, stable);

        // Reset while waiting in WR_RESP.
        b_dly = 6;
        c = mk(1, 4'hC, 32'h12345678, 4'hF, 0).cmd;
        send_cmd(c);
        n = 0;
        while (!BREADY && n < 20) begin tick(); n++; end
        chk("reach_wr_resp", BREADY, 1);
        ARESETn = 0;
        tick();
        rst_chk("midrst");
        ARESETn = 1;
        b_dly = 0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        tick();
        c = mk(0, 4'hC, 0, 0, 0).cmd;
        run_check("after_rst", c, model[3], 0, lat, stable);

`ifdef AXIM_TIMEOUT_EN
        // Slave never returns read data: watchdog closes the transaction.
        r_never = 1;
        begin
            bit iw, er; logic [31:0] rd; logic [4:0] ax;
            c = mk(0, 4'h0, 0, 0, 0).cmd;
            send_cmd(c);
            get_rsp(0, iw, rd, er, lat, stable, ax);
            chk("to_latency", lat, 17);
            chk("to_err", er, 1);
            chk("to_rdata", rd, 0);
            chk("to_is_write", iw, 0);
            chk("to_axi_idle", ax, 0);
        end
        r_never = 0;
        ARESETn = 0; tick(); tick(); ARESETn = 1; tick();
        for (int i = 0; i < 4; i++) model[i] = 0;
`endif

        // Randomized traffic against the register model.
        for (int i = 0; i < 60; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            c.write = 1'($urandom_range(0, 1));
            c.addr  = 4'($urandom);
            c.wdata = $urandom;
            c.wstrb = 4'($urandom);
            run_check($sformatf("rnd%0d", i), c, c.write ? 32'h0 : model[c.addr[3:2]],
                      $urandom_range(0, 3), lat, stable);
            chk($sformatf("rnd%0d_stable", i), stable, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
